// File: rtl/event_report_pkg.sv
// Shared definitions for the event report scheduler: FSM states, source IDs
// and the I2C slave register map.
package event_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SHOUT = 2'd1,
    SRC_GLASS = 2'd2,
    SRC_BF    = 2'd3
  } src_t;

  localparam logic [2:0] ADDR_SHOUT = 3'd1;
  localparam logic [2:0] ADDR_GLASS = 3'd2;
  localparam logic [2:0] ADDR_BF    = 3'd3;

  localparam int CNT_W = 8;

  // Register address owned by each reporting source.
  function automatic logic [2:0] src_addr(input src_t src);
    case (src)
      SRC_SHOUT: return ADDR_SHOUT;
      SRC_GLASS: return ADDR_GLASS;
      SRC_BF:    return ADDR_BF;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/event_report_scheduler_if.sv
// Register-write bus between the scheduler and the I2C slave register file.
interface event_report_scheduler_if;

  logic       i2c_intr_l;
  logic       i2c_cs_l;
  logic       i2c_rw_l;
  logic [2:0] i2c_addr;
  logic [7:0] i2c_data;

  modport master (
    input  i2c_intr_l,
    output i2c_cs_l,
    output i2c_rw_l,
    output i2c_addr,
    output i2c_data
  );

  modport slave (
    output i2c_intr_l,
    input  i2c_cs_l,
    input  i2c_rw_l,
    input  i2c_addr,
    input  i2c_data
  );

endinterface

// File: rtl/event_source_latch.sv
// Per-source event latch: rising-edge detect on a classifier level, a pending
// flag for the scheduler, and a saturating count of edges since last report.
module event_source_latch
  import event_report_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             evt,
  input  logic             clr,
  output logic             pending,
  output logic [CNT_W-1:0] count
);

  logic evt_prev;
  logic rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rise = evt & ~evt_prev;

  // Edge register, pending flag and counter; an edge coinciding with the
  // grant that clears this source starts a fresh count of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_prev <= 1'b0;
      pending  <= 1'b0;
      count    <= '0;
    end else begin
      evt_prev <= evt;
      if (rise) begin
        pending <= 1'b1;
        count   <= clr ? CNT_W'(1) : sat_inc(count);
      end else if (clr) begin
        pending <= 1'b0;
        count   <= '0;
      end
    end
  end

endmodule

// File: rtl/event_report_scheduler.sv
// Collects glass/shout classifier events and beamforming results and reports
// them one at a time as register writes to the I2C slave.
module event_report_scheduler
  import event_report_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            glass,
  input  logic                            shout,
  input  logic                            bf_valid,
  input  logic [7:0]                      led_pattern,
  event_report_scheduler_if.master        i2c,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int TMR_MAX = (ACK_TIMEOUT > HOLD_CYCLES) ? ACK_TIMEOUT : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] timer;
  src_t             grant_src;
  logic             ack_timeout;

  logic             shout_pend;
  logic             glass_pend;
  logic [CNT_W-1:0] shout_cnt;
  logic [CNT_W-1:0] glass_cnt;
  logic             pend_bf;
  logic [7:0]       bf_pat;
  logic [7:0]       grant_data;

  logic [2:0]       addr_q;
  logic [7:0]       data_q;

  event_source_latch u_shout (
    .clk     (clk),
    .reset   (reset),
    .evt     (shout),
    .clr     (grant_src == SRC_SHOUT),
    .pending (shout_pend),
    .count   (shout_cnt)
  );

  event_source_latch u_glass (
    .clk     (clk),
    .reset   (reset),
    .evt     (glass),
    .clr     (grant_src == SRC_GLASS),
    .pending (glass_pend),
    .count   (glass_cnt)
  );

  // Beamforming capture: latest pattern wins until the source is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_bf <= 1'b0;
      bf_pat  <= '0;
    end else if (bf_valid) begin
      pend_bf <= 1'b1;
      bf_pat  <= led_pattern;
    end else if (grant_src == SRC_BF) begin
      pend_bf <= 1'b0;
    end
  end

  // State register and phase timer; the timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == ST_IDLE) timer <= '0;
      else                                        timer <= timer + 1'b1;
    end
  end

  // Next-state logic with fixed-priority grant shout > glass > bf.
  always_comb begin
    state_next  = state;
    grant_src   = SRC_NONE;
    ack_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (shout_pend) begin
          grant_src  = SRC_SHOUT;
          state_next = ST_SETUP;
        end else if (glass_pend) begin
          grant_src  = SRC_GLASS;
          state_next = ST_SETUP;
        end else if (pend_bf) begin
          grant_src  = SRC_BF;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: if (timer == HOLD_LAST) state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!i2c.i2c_intr_l) begin
          state_next = ST_DONE;
        end else if (timer == ACK_LAST) begin
          state_next  = ST_DONE;
          ack_timeout = 1'b1;
        end
      end
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Payload of the granted source.
  always_comb begin
    grant_data = '0;
    case (grant_src)
      SRC_SHOUT: grant_data = shout_cnt;
      SRC_GLASS: grant_data = glass_cnt;
      SRC_BF:    grant_data = bf_pat;
      default:   grant_data = '0;
    endcase
  end

  // Address/data latched at grant and held stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (grant_src != SRC_NONE) begin
      addr_q <= src_addr(grant_src);
      data_q <= grant_data;
    end
  end

  // Sticky acknowledge-timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)            err_timeout <= 1'b0;
    else if (ack_timeout) err_timeout <= 1'b1;
  end

  assign i2c.i2c_cs_l = (state != ST_STROBE);
  assign i2c.i2c_rw_l = (state != ST_STROBE);
  assign i2c.i2c_addr = addr_q;
  assign i2c.i2c_data = data_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_event_report_scheduler.sv
// Directed bench for event_report_scheduler with a per-cycle reference model.
`timescale 1ns/1ps
module tb_event_report_scheduler;

  localparam int HOLD = 4;
  localparam int TO   = 1023;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       glass       = 1'b0;
  logic       shout       = 1'b0;
  logic       bf_valid    = 1'b0;
  logic [7:0] led_pattern = 8'h00;
  logic       intr_l      = 1'b1;
  logic       busy;
  logic       err_timeout;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  event_report_scheduler_if bus ();
  assign bus.i2c_intr_l = intr_l;

  event_report_scheduler #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .glass       (glass),
    .shout       (shout),
    .bf_valid    (bf_valid),
    .led_pattern (led_pattern),
    .i2c         (bus),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending sources, counts, and a transfer timeline
  // measured in cycles since grant.
  bit         m_prev_g, m_prev_s, m_pend_s, m_pend_g, m_pend_b;
  int         m_cnt_s, m_cnt_g;
  logic [7:0] m_pat, m_data;
  logic [2:0] m_addr;
  bit         m_active, m_done, m_err;
  int         m_t, m_w;

  always @(posedge clk) begin : model
    bit rs, rg, gs, gg, gb;
    if (reset) begin
      m_prev_g = 0; m_prev_s = 0; m_pend_s = 0; m_pend_g = 0; m_pend_b = 0;
      m_cnt_s = 0; m_cnt_g = 0; m_pat = 0; m_data = 0; m_addr = 0;
      m_active = 0; m_done = 0; m_err = 0; m_t = 0; m_w = 0;
    end else begin
      rs = shout && !m_prev_s;
      rg = glass && !m_prev_g;
      m_prev_s = shout;
      m_prev_g = glass;
      gs = 0; gg = 0; gb = 0;
      if (m_active) begin
        if (m_done) m_active = 0;
        else if (m_t > HOLD) begin
          if (!intr_l) m_done = 1;
          else if (m_w == TO - 1) begin m_done = 1; m_err = 1; end
          else m_w++;
        end else m_t++;
      end else if (m_pend_s || m_pend_g || m_pend_b) begin
        if (m_pend_s)      begin gs = 1; m_addr = 3'd1; m_data = 8'(m_cnt_s); end
        else if (m_pend_g) begin gg = 1; m_addr = 3'd2; m_data = 8'(m_cnt_g); end
        else               begin gb = 1; m_addr = 3'd3; m_data = m_pat; end
        m_active = 1; m_done = 0; m_t = 0; m_w = 0;
      end
      if (rs) begin m_pend_s = 1; m_cnt_s = gs ? 1 : (m_cnt_s < 255 ? m_cnt_s + 1 : 255); end
      else if (gs) begin m_pend_s = 0; m_cnt_s = 0; end
      if (rg) begin m_pend_g = 1; m_cnt_g = gg ? 1 : (m_cnt_g < 255 ? m_cnt_g + 1 : 255); end
      else if (gg) begin m_pend_g = 0; m_cnt_g = 0; end
      if (bf_valid) begin m_pend_b = 1; m_pat = led_pattern; end
      else if (gb) m_pend_b = 0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : compare
    logic exp_cs;
    if (chk_en) begin
      exp_cs = (m_active && !m_done && m_t >= 1 && m_t <= HOLD) ? 1'b0 : 1'b1;
      check("cs_l", 32'(bus.i2c_cs_l), 32'(exp_cs));
      check("rw_l", 32'(bus.i2c_rw_l), 32'(exp_cs));
      check("busy", 32'(busy), 32'(m_active));
      check("addr", 32'(bus.i2c_addr), 32'(m_addr));
      check("data", 32'(bus.i2c_data), 32'(m_data));
      check("err_timeout", 32'(err_timeout), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return bus.i2c_cs_l == 1'b0;
      1:       return busy == 1'b0;
      2:       return busy == 1'b1;
      default: return bus.i2c_cs_l == 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int what, input int maxc, input string nm);
    int n = 0;
    while (!cond(what) && n < maxc) begin
      step();
      n++;
    end
    if (!cond(what)) begin
      checks++;
      failures++;
      $display("FAIL %s: condition not reached, waited %0d cycles required <= %0d", nm, n, maxc);
    end
  endtask

  initial begin : stim
    int n;
    repeat (2) step();
    chk_en = 1'b1;
    step();
    check("rst_cs_l", 32'(bus.i2c_cs_l), 32'd1);
    check("rst_rw_l", 32'(bus.i2c_rw_l), 32'd1);
    check("rst_addr", 32'(bus.i2c_addr), 32'd0);
    check("rst_data", 32'(bus.i2c_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b0;
    step();

    // Single glass pulse, ack two cycles into WAIT_ACK.
    glass = 1'b1; step(); glass = 1'b0;
    check("s1_busy_e0", 32'(busy), 32'd0);
    step();
    check("s1_setup_busy", 32'(busy), 32'd1);
    check("s1_setup_cs", 32'(bus.i2c_cs_l), 32'd1);
    step();
    check("s1_cs_e2", 32'(bus.i2c_cs_l), 32'd0);
    check("s1_addr", 32'(bus.i2c_addr), 32'd2);
    check("s1_data", 32'(bus.i2c_data), 32'd1);
    n = 0;
    while (bus.i2c_cs_l == 1'b0 && n < 20) begin n++; step(); end
    check("s1_cs_len", 32'(n), 32'd4);
    step();
    intr_l = 1'b0; step(); intr_l = 1'b1;
    check("s1_done_busy", 32'(busy), 32'd1);
    step();
    check("s1_idle_busy", 32'(busy), 32'd0);
    check("s1_err", 32'(err_timeout), 32'd0);

    // Shout and glass together.
    intr_l = 1'b0;
    shout = 1'b1; glass = 1'b1; step(); shout = 1'b0; glass = 1'b0;
    wait_for(0, 10, "s2_cs1");
    check("s2_addr1", 32'(bus.i2c_addr), 32'd1);
    check("s2_data1", 32'(bus.i2c_data), 32'd1);
    wait_for(1, 20, "s2_idle");
    n = 0;
    while (!busy && n < 10) begin n++; step(); end
    check("s2_idle_gap", 32'(n), 32'd1);
    wait_for(0, 10, "s2_cs2");
    check("s2_addr2", 32'(bus.i2c_addr), 32'd2);
    check("s2_data2", 32'(bus.i2c_data), 32'd1);
    wait_for(1, 20, "s2_end");

    // Three glass edges during a bf transfer.
    intr_l = 1'b1;
    led_pattern = 8'h5A; bf_valid = 1'b1; step(); bf_valid = 1'b0;
    wait_for(0, 10, "s3_cs_bf");
    check("s3_addr_bf", 32'(bus.i2c_addr), 32'd3);
    check("s3_data_bf", 32'(bus.i2c_data), 32'h5A);
    repeat (3) begin glass = 1'b1; step(); glass = 1'b0; step(); end
    check("s3_still_busy", 32'(busy), 32'd1);
    intr_l = 1'b0;
    wait_for(1, 20, "s3_bf_end");
    wait_for(0, 10, "s3_cs_g");
    check("s3_addr_g", 32'(bus.i2c_addr), 32'd2);
    check("s3_data_g", 32'(bus.i2c_data), 32'd3);
    wait_for(1, 20, "s3_end");

    // Two bf results before grant: latest wins.
    glass = 1'b1; step(); glass = 1'b0;
    step();
    led_pattern = 8'h0F; bf_valid = 1'b1; step();
    led_pattern = 8'hF0; step(); bf_valid = 1'b0;
    wait_for(1, 20, "s4_g_end");
    wait_for(0, 10, "s4_cs_bf");
    check("s4_addr", 32'(bus.i2c_addr), 32'd3);
    check("s4_data", 32'(bus.i2c_data), 32'hF0);
    wait_for(1, 20, "s4_end");
    n = 0;
    repeat (5) begin step(); if (busy) n++; end
    check("s4_single_report", 32'(n), 32'd0);

    // Acknowledge timeout.
    intr_l = 1'b1;
    glass = 1'b1; step(); glass = 1'b0;
    wait_for(0, 10, "s5_cs");
    wait_for(3, 10, "s5_cs_end");
    n = 0;
    while (busy && n < 1100) begin n++; step(); end
    check("s5_wait_len", 32'(n), 32'd1024);
    check("s5_err", 32'(err_timeout), 32'd1);
    repeat (5) step();
    check("s5_err_sticky", 32'(err_timeout), 32'd1);

    // Reset during STROBE with a shout pending.
    glass = 1'b1; step(); glass = 1'b0;
    wait_for(0, 10, "s6_cs");
    shout = 1'b1; step(); shout = 1'b0;
    reset = 1'b1; step();
    check("s6_cs_l", 32'(bus.i2c_cs_l), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_err", 32'(err_timeout), 32'd0);
    check("s6_addr", 32'(bus.i2c_addr), 32'd0);
    reset = 1'b0;
    n = 0;
    repeat (6) begin step(); if (busy) n++; end
    check("s6_discarded", 32'(n), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
